// File: rtl/signed_div_seq_pkg.sv
// rtl/signed_div_seq_pkg.sv - shared state encoding and sizing helpers for the signed divider
package signed_div_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Bit counter must hold the value WL itself, hence the extra bit.
  function automatic int cnt_width(input int wl);
    return $clog2(wl) + 1;
  endfunction

endpackage

// File: rtl/signed_div_seq_div_mag.sv
// rtl/signed_div_seq_div_mag.sv - two's-complement operand to sign plus unsigned magnitude
module div_mag #(
  parameter int WL = 4
) (
  input  logic [WL-1:0] x,
  output logic          sign,
  output logic [WL-1:0] mag
);

  logic [WL-1:0] neg;

  // The most-negative input negates to itself, which read unsigned is 2^(WL-1).
  assign neg  = '0 - x;
  assign sign = x[WL-1];
  assign mag  = sign ? neg : x;

endmodule

// File: rtl/signed_div_seq.sv
// rtl/signed_div_seq.sv - iterative restoring signed divider, one quotient bit per clock
module signed_div_seq
  import signed_div_seq_pkg::*;
#(
  parameter int WL = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [WL-1:0] dividend,
  input  logic [WL-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [WL-1:0] quotient,
  output logic [WL-1:0] remainder,
  output logic          div_by_zero,
  output logic          overflow
);

  localparam int CW = cnt_width(WL);
  localparam logic [WL-1:0] MOST_NEG = {1'b1, {(WL-1){1'b0}}};
  localparam logic [WL-1:0] ONE      = {{(WL-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WL:0]   prem_q, prem_d;
  logic [WL-1:0] dvd_q, dvd_d;
  logic [WL-1:0] dsr_q, dsr_d;
  logic [WL-1:0] a_raw_q, a_raw_d;
  logic          sa_q, sa_d, sb_q, sb_d;
  logic          pend_q, pend_d;
  logic          done_q, done_d;
  logic [WL-1:0] quo_q, quo_d, rem_q, rem_d;
  logic          dz_q, dz_d, ovf_q, ovf_d;

  logic          a_sign, b_sign;
  logic [WL-1:0] a_mag, b_mag;
  logic [WL+1:0] shifted;

  div_mag #(.WL(WL)) u_mag_a (.x(dividend), .sign(a_sign), .mag(a_mag));
  div_mag #(.WL(WL)) u_mag_b (.x(divisor),  .sign(b_sign), .mag(b_mag));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    a_raw_d = a_raw_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    pend_d  = 1'b0;
    done_d  = pend_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    shifted = {prem_q, dvd_q[WL-1]};

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a_sign;
          sb_d    = b_sign;
          dvd_d   = a_mag;
          dsr_d   = b_mag;
          a_raw_d = dividend;
          prem_d  = '0;
          cnt_d   = CW'(WL);
          state_d = RUN;
        end
      end
      RUN: begin
        // Dividend magnitude register doubles as the quotient shift register.
        if (shifted >= {2'b00, dsr_q}) begin
          prem_d = (WL+1)'(shifted - {2'b00, dsr_q});
          dvd_d  = {dvd_q[WL-2:0], 1'b1};
        end else begin
          prem_d = shifted[WL:0];
          dvd_d  = {dvd_q[WL-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (dsr_q == '0) begin
          quo_d = '1;
          rem_d = a_raw_q;
          dz_d  = 1'b1;
          ovf_d = 1'b0;
        end else begin
          quo_d = (sa_q ^ sb_q) ? ('0 - dvd_q) : dvd_q;
          rem_d = sa_q ? ('0 - prem_q[WL-1:0]) : prem_q[WL-1:0];
          dz_d  = 1'b0;
          ovf_d = sb_q && (dsr_q == ONE) && (a_raw_q == MOST_NEG);
        end
        pend_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      a_raw_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      a_raw_q <= a_raw_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;
  assign overflow    = ovf_q;

endmodule
